// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Combines load-use hazards, EX-stage mispredicts, multi-cycle DM accesses
// and halt into per-register enables and bubble strobes, and keeps
// saturating stall/flush statistics plus a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_ex_dm,
  input  logic             dm_access,
  input  logic             dm_ready,
  input  logic             mispredict_ex,
  input  logic             memtoreg_id_ex,
  input  logic             regfile_w_en_id_ex,
  input  logic [4:0]       regfile_req_w_id_ex,
  input  logic [4:0]       rs_if_id,
  input  logic [4:0]       rt_if_id,
  input  logic             rs_used,
  input  logic             rt_used,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_dm_en,
  output logic             dm_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_e;

  localparam logic [7:0]       TIMEOUT_C = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic             ld_use_s;
  logic             mem_busy_s;
  // enable vector order: {pc, if_id, id_ex, ex_dm, dm_wb}
  logic [4:0]       norm_en_s;
  logic             norm_if_fl_s;
  logic             norm_id_fl_s;
  logic             norm_flush_ev_s;
  logic [4:0]       en_s;
  logic             if_fl_s;
  logic             id_fl_s;
  logic             flush_ev_s;
  logic             stall_ev_s;

  assign ld_use_s = memtoreg_id_ex & regfile_w_en_id_ex &
                    (regfile_req_w_id_ex != 5'd0) &
                    ((rs_used & (rs_if_id == regfile_req_w_id_ex)) |
                     (rt_used & (rt_if_id == regfile_req_w_id_ex)));
  assign mem_busy_s = dm_access & ~dm_ready;

  // Normal-flow decision: mispredict squashes ID anyway, so it outranks ld_use.
  always_comb begin
    norm_en_s       = 5'b11111;
    norm_if_fl_s    = 1'b0;
    norm_id_fl_s    = 1'b0;
    norm_flush_ev_s = 1'b0;
    if (mispredict_ex) begin
      norm_if_fl_s    = 1'b1;
      norm_id_fl_s    = 1'b1;
      norm_flush_ev_s = 1'b1;
    end else if (ld_use_s) begin
      norm_en_s    = 5'b00111;
      norm_id_fl_s = 1'b1;
    end else begin
      norm_en_s = 5'b11111;
    end
  end

  // Next-state, wait counter, error flag and strobe selection.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    mem_err_d  = mem_err_q;
    en_s       = 5'b00000;
    if_fl_s    = 1'b0;
    id_fl_s    = 1'b0;
    flush_ev_s = 1'b0;
    case (state_q)
      S_RUN: begin
        if (halt_ex_dm) begin
          state_d = S_HALT;
        end else if (mem_busy_s) begin
          state_d = S_MEM_WAIT;
          wait_d  = 8'd1;
        end else begin
          en_s       = norm_en_s;
          if_fl_s    = norm_if_fl_s;
          id_fl_s    = norm_id_fl_s;
          flush_ev_s = norm_flush_ev_s;
        end
      end
      S_MEM_WAIT: begin
        if (dm_ready) begin
          en_s       = norm_en_s;
          if_fl_s    = norm_if_fl_s;
          id_fl_s    = norm_id_fl_s;
          flush_ev_s = norm_flush_ev_s;
          state_d    = S_RUN;
          wait_d     = 8'd0;
        end else if (wait_q == TIMEOUT_C) begin
          mem_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RUN;
        wait_d  = 8'd0;
      end
    endcase
  end

  assign stall_ev_s = ~en_s[4] & (state_q != S_HALT);

  // Saturating statistics counters.
  always_comb begin
    if (stall_ev_s && (stall_q != CNT_MAX_C)) begin
      stall_d = stall_q + CNT_ONE_C;
    end else begin
      stall_d = stall_q;
    end
    if (flush_ev_s && (flush_q != CNT_MAX_C)) begin
      flush_d = flush_q + CNT_ONE_C;
    end else begin
      flush_d = flush_q;
    end
  end

  // State and statistics registers; async reset aborts any wait without error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      wait_q    <= 8'd0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  // Everything is held quiet while reset is asserted.
  assign pc_en       = en_s[4] & ~rst;
  assign if_id_en    = en_s[3] & ~rst;
  assign id_ex_en    = en_s[2] & ~rst;
  assign ex_dm_en    = en_s[1] & ~rst;
  assign dm_wb_en    = en_s[0] & ~rst;
  assign if_id_flush = if_fl_s & ~rst;
  assign id_ex_flush = id_fl_s & ~rst;
  assign halted      = (state_q == S_HALT) & ~rst;
  assign mem_err     = mem_err_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized
// stimulus checked against a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic halt_ex_dm, dm_access, dm_ready, mispredict_ex;
  logic memtoreg_id_ex, regfile_w_en_id_ex;
  logic [4:0] regfile_req_w_id_ex, rs_if_id, rt_if_id;
  logic rs_used, rt_used;
  logic pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en;
  logic if_id_flush, id_ex_flush, halted, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [4:0] en_v;
  logic [1:0] fl_v;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int m_wait;
  bit m_halt, m_err;
  int m_stall, m_flush;

  assign en_v = {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en};
  assign fl_v = {if_id_flush, id_ex_flush};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .halt_ex_dm(halt_ex_dm), .dm_access(dm_access), .dm_ready(dm_ready),
    .mispredict_ex(mispredict_ex), .memtoreg_id_ex(memtoreg_id_ex),
    .regfile_w_en_id_ex(regfile_w_en_id_ex), .regfile_req_w_id_ex(regfile_req_w_id_ex),
    .rs_if_id(rs_if_id), .rt_if_id(rt_if_id), .rs_used(rs_used), .rt_used(rt_used),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_dm_en(ex_dm_en),
    .dm_wb_en(dm_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic set_idle();
    halt_ex_dm = 1'b0; dm_access = 1'b0; dm_ready = 1'b0; mispredict_ex = 1'b0;
    memtoreg_id_ex = 1'b0; regfile_w_en_id_ex = 1'b0; regfile_req_w_id_ex = 5'd0;
    rs_if_id = 5'd0; rt_if_id = 5'd0; rs_used = 1'b0; rt_used = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_ld_use(input logic [4:0] dest);
    memtoreg_id_ex = 1'b1; regfile_w_en_id_ex = 1'b1; regfile_req_w_id_ex = dest;
    rs_if_id = dest; rs_used = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    #1;
    n_tests++;
    if (en_v !== 5'b00000 || fl_v !== 2'b00 || halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: en=%b fl=%b halted=%b, required 00000 00 0", en_v, fl_v, halted);
    end
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (en_v !== 5'b11111 || fl_v !== 2'b00 || halted !== 1'b0 || mem_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: en=%b fl=%b halted=%b err=%b, required 11111 00 0 0", en_v, fl_v, halted, mem_err);
    end
    n_tests++;
    if (stall_cnt !== 6'd0 || flush_cnt !== 6'd0) begin
      n_fail++; $display("FAIL reset_cnt: stall=%0d flush=%0d, required 0 0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_ld_use(5'd5);
    #1;
    n_tests++;
    if (en_v !== 5'b00111 || fl_v !== 2'b01) begin
      n_fail++; $display("FAIL ld_use: en=%b fl=%b, required 00111 01", en_v, fl_v);
    end
    tick();
    set_idle();
    #1;
    n_tests++;
    if (stall_cnt !== 6'd1) begin
      n_fail++; $display("FAIL ld_use_stall: stall=%0d, required 1", stall_cnt);
    end
    set_ld_use(5'd0);
    #1;
    n_tests++;
    if (en_v !== 5'b11111 || fl_v !== 2'b00) begin
      n_fail++; $display("FAIL ld_use_r0: en=%b fl=%b, required 11111 00", en_v, fl_v);
    end
    tick();
    n_tests++;
    if (stall_cnt !== 6'd1) begin
      n_fail++; $display("FAIL ld_use_r0_stall: stall=%0d, required 1", stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    dm_access = 1'b1; dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (en_v !== 5'b00000) begin
        n_fail++; $display("FAIL mem_wait_%0d: en=%b, required 00000", i, en_v);
      end
      tick();
    end
    dm_ready = 1'b1;
    #1;
    n_tests++;
    if (en_v !== 5'b11111) begin
      n_fail++; $display("FAIL mem_done: en=%b, required 11111", en_v);
    end
    tick();
    set_idle();
    #1;
    n_tests++;
    if (en_v !== 5'b11111 || stall_cnt !== 6'd3 || halted !== 1'b0) begin
      n_fail++; $display("FAIL mem_after: en=%b stall=%0d halted=%b, required 11111 3 0", en_v, stall_cnt, halted);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    dm_access = 1'b1; dm_ready = 1'b0;
    for (int i = 0; i < TO + 1; i++) begin
      #1;
      n_tests++;
      if (en_v !== 5'b00000 || mem_err !== 1'b0 || halted !== 1'b0) begin
        n_fail++; $display("FAIL timeout_wait_%0d: en=%b err=%b halted=%b, required 00000 0 0", i, en_v, mem_err, halted);
      end
      tick();
    end
    n_tests++;
    if (mem_err !== 1'b1 || halted !== 1'b1 || stall_cnt !== 6'd5) begin
      n_fail++; $display("FAIL timeout_err: err=%b halted=%b stall=%0d, required 1 1 5", mem_err, halted, stall_cnt);
    end
    dm_ready = 1'b1; mispredict_ex = 1'b1;
    tick();
    tick();
    n_tests++;
    if (en_v !== 5'b00000 || fl_v !== 2'b00 || stall_cnt !== 6'd5 || mem_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_frozen: en=%b fl=%b stall=%0d err=%b, required 00000 00 5 1", en_v, fl_v, stall_cnt, mem_err);
    end
  endtask

  task automatic test_mispredict_lduse();
    do_reset();
    set_ld_use(5'd7);
    mispredict_ex = 1'b1;
    #1;
    n_tests++;
    if (en_v !== 5'b11111 || fl_v !== 2'b11) begin
      n_fail++; $display("FAIL mispredict_lduse: en=%b fl=%b, required 11111 11", en_v, fl_v);
    end
    tick();
    set_idle();
    #1;
    n_tests++;
    if (flush_cnt !== 6'd1 || stall_cnt !== 6'd0) begin
      n_fail++; $display("FAIL mispredict_cnt: flush=%0d stall=%0d, required 1 0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_halt();
    do_reset();
    halt_ex_dm = 1'b1;
    #1;
    n_tests++;
    if (en_v !== 5'b00000 || halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_enter: en=%b halted=%b, required 00000 0", en_v, halted);
    end
    tick();
    halt_ex_dm = 1'b0; mispredict_ex = 1'b1; dm_access = 1'b1; dm_ready = 1'b1;
    #1;
    n_tests++;
    if (halted !== 1'b1 || en_v !== 5'b00000 || fl_v !== 2'b00) begin
      n_fail++; $display("FAIL halt_frozen: halted=%b en=%b fl=%b, required 1 00000 00", halted, en_v, fl_v);
    end
    tick();
    tick();
    n_tests++;
    if (flush_cnt !== 6'd0 || stall_cnt !== 6'd1 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_cnt: flush=%0d stall=%0d halted=%b, required 0 1 1", flush_cnt, stall_cnt, halted);
    end
    set_idle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (halted !== 1'b0 || en_v !== 5'b11111 || stall_cnt !== 6'd0 || flush_cnt !== 6'd0) begin
      n_fail++; $display("FAIL halt_rst: halted=%b en=%b stall=%0d flush=%0d, required 0 11111 0 0", halted, en_v, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    dm_access = 1'b1; dm_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (en_v !== 5'b00000 || fl_v !== 2'b00) begin
      n_fail++; $display("FAIL midwait_rst_hold: en=%b fl=%b, required 00000 00", en_v, fl_v);
    end
    set_idle();
    rst = 1'b0;
    #1;
    for (int i = 0; i < TO + 2; i++) tick();
    n_tests++;
    if (mem_err !== 1'b0 || halted !== 1'b0 || en_v !== 5'b11111 || stall_cnt !== 6'd0) begin
      n_fail++; $display("FAIL midwait_after: err=%b halted=%b en=%b stall=%0d, required 0 0 11111 0", mem_err, halted, en_v, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_ld_use(5'd3);
    for (int i = 0; i < CMAX + 6; i++) tick();
    set_idle();
    mispredict_ex = 1'b1;
    for (int i = 0; i < CMAX + 6; i++) tick();
    set_idle();
    #1;
    n_tests++;
    if (stall_cnt !== 6'(CMAX) || flush_cnt !== 6'(CMAX)) begin
      n_fail++; $display("FAIL saturation: stall=%0d flush=%0d, required %0d %0d", stall_cnt, flush_cnt, CMAX, CMAX);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_halt = 1'b0; m_err = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  task automatic test_random();
    bit lu, busy, normal, fl_ev, nh, ne;
    int nw;
    logic [4:0] e_en;
    logic [1:0] e_fl;
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        #1;
        n_tests++;
        if (en_v !== 5'b00000 || fl_v !== 2'b00 || halted !== 1'b0) begin
          n_fail++; $display("FAIL rnd_rst c=%0d: en=%b fl=%b halted=%b, required 00000 00 0", c, en_v, fl_v, halted);
        end
        rst = 1'b0;
        model_reset();
        #1;
      end
      dm_access = ($urandom_range(0, 2) == 0);
      dm_ready = $urandom_range(0, 1);
      halt_ex_dm = ~dm_access & ($urandom_range(0, 199) == 0);
      mispredict_ex = ($urandom_range(0, 4) == 0);
      memtoreg_id_ex = $urandom_range(0, 1);
      regfile_w_en_id_ex = $urandom_range(0, 1);
      regfile_req_w_id_ex = 5'($urandom_range(0, 3));
      rs_if_id = 5'($urandom_range(0, 3));
      rt_if_id = 5'($urandom_range(0, 3));
      rs_used = $urandom_range(0, 1);
      rt_used = $urandom_range(0, 1);
      #1;
      lu = memtoreg_id_ex && regfile_w_en_id_ex && (regfile_req_w_id_ex != 0) &&
           ((rs_used && rs_if_id == regfile_req_w_id_ex) || (rt_used && rt_if_id == regfile_req_w_id_ex));
      busy = dm_access && !dm_ready;
      e_en = 5'b00000; e_fl = 2'b00; fl_ev = 1'b0; normal = 1'b0;
      nw = m_wait; nh = m_halt; ne = m_err;
      if (m_halt) begin
        nh = 1'b1;
      end else if (m_wait == 0) begin
        if (halt_ex_dm) nh = 1'b1;
        else if (busy) nw = 1;
        else normal = 1'b1;
      end else if (dm_ready) begin
        normal = 1'b1; nw = 0;
      end else if (m_wait == TO) begin
        ne = 1'b1; nh = 1'b1;
      end else begin
        nw = m_wait + 1;
      end
      if (normal) begin
        if (mispredict_ex) begin e_en = 5'b11111; e_fl = 2'b11; fl_ev = 1'b1; end
        else if (lu) begin e_en = 5'b00111; e_fl = 2'b01; end
        else e_en = 5'b11111;
      end
      n_tests++;
      if (en_v !== e_en || fl_v !== e_fl) begin
        n_fail++; $display("FAIL rnd_strobes c=%0d: en=%b fl=%b, required %b %b", c, en_v, fl_v, e_en, e_fl);
      end
      n_tests++;
      if (halted !== m_halt || mem_err !== m_err) begin
        n_fail++; $display("FAIL rnd_status c=%0d: halted=%b err=%b, required %b %b", c, halted, mem_err, m_halt, m_err);
      end
      n_tests++;
      if (stall_cnt !== 6'(m_stall) || flush_cnt !== 6'(m_flush)) begin
        n_fail++; $display("FAIL rnd_cnt c=%0d: stall=%0d flush=%0d, required %0d %0d", c, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      tick();
      if (!m_halt && !e_en[4] && m_stall < CMAX) m_stall++;
      if (fl_ev && m_flush < CMAX) m_flush++;
      m_wait = nw; m_halt = nh; m_err = ne;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_mispredict_lduse();
    test_halt();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It generates the enable and flush strobes for PC, IF/ID, ID/EX, EX/DM and DM/WB registers from four sources: load-use hazards, EX-stage branch mispredicts, multi-cycle data-memory accesses in the DM stage, and halt. It also keeps saturating stall/flush statistics and a memory-timeout error flag.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before mem_err; range 1..255
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
halt_ex_dm  in  1  halt instruction present in DM stage
dm_access  in  1  DM stage holds a load or store (memtoreg_ex_dm | datamem_w_en_ex_dm)
dm_ready  in  1  data memory completes access this cycle
mispredict_ex  in  1  branch in EX resolved opposite to BHT prediction
memtoreg_id_ex  in  1  instruction in EX is a load
regfile_w_en_id_ex  in  1  instruction in EX writes the register file
regfile_req_w_id_ex  in  5  destination register of instruction in EX
rs_if_id, rt_if_id  in  5 each  source registers of instruction in ID
rs_used, rt_used  in  1 each  ID instruction actually reads rs / rt
pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en  out  1 each  register enables
if_id_flush, id_ex_flush  out  1 each  load bubble (zeros) into IF/ID / ID/EX
halted  out  1  pipeline frozen by halt or timeout
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALT
flush_cnt  out  CNT_W  mispredict flush events

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- States: RUN, MEM_WAIT, HALT. Registered: state, wait counter (8 b), mem_err, stall_cnt, flush_cnt.
- Enables and flushes are combinational from the state and the inputs; the registers update on the clk edge.
- Reset: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0. While rst=1, all enables=0, flushes=0, halted=0.
- ld_use = memtoreg_id_ex & regfile_w_en_id_ex & (regfile_req_w_id_ex!=0) & ((rs_used & rs_if_id==regfile_req_w_id_ex) | (rt_used & rt_if_id==regfile_req_w_id_ex)).
- mem_busy = dm_access & ~dm_ready.
- RUN priority, highest first:
  1. halt_ex_dm: all enables 0; next state HALT.
  2. mem_busy: all enables 0; next MEM_WAIT; wait_cnt<=1.
  3. mispredict_ex: all enables 1; if_id_flush=1, id_ex_flush=1; flush_cnt+1.
  4. ld_use: pc_en=0, if_id_en=0; id_ex_en=1, id_ex_flush=1; ex_dm_en=1, dm_wb_en=1.
  5. Otherwise all enables 1 and no flush.
- Mispredict outranks ld_use: the flushed ID instruction is squashed anyway.
- MEM_WAIT:
  - dm_ready=1: the cycle is evaluated exactly as RUN rules 3-5, with the held mispredict/ld_use inputs still valid; next state RUN; wait_cnt<=0.
  - dm_ready=0 and wait_cnt==MEM_TIMEOUT: all enables 0; mem_err<=1; next HALT.
  - Otherwise all enables 0 and wait_cnt+1.
  - halt_ex_dm is ignored in MEM_WAIT; halt is never in DM together with a memory access.
- HALT: all enables 0, no flushes, halted=1. Exit only via rst.
- stall_cnt increments on every cycle with pc_en=0 and state≠HALT, including the cycle that enters HALT.
- stall_cnt and flush_cnt saturate at all-ones and do not wrap.
- mem_err stays set until reset.
- Reset asserted mid-MEM_WAIT aborts the wait immediately; no mem_err is raised.

Test Plan:
- Reset then idle inputs → all enables 1, flushes 0, stall_cnt=0, flush_cnt=0, halted=0.
- memtoreg_id_ex=1, regfile_w_en_id_ex=1, regfile_req_w_id_ex=5, rs_if_id=5, rs_used=1 for one cycle → pc_en=if_id_en=0, id_ex_flush=1, stall_cnt=1. Repeat with dest=0 → no stall.
- dm_access=1 with dm_ready low for 3 cycles, then high → all enables 0 for 3 cycles, enables 1 on the 4th, state RUN, stall_cnt=3.
- MEM_TIMEOUT=4, dm_access=1, dm_ready held 0 → mem_err=1 and halted=1 after the 5th wait cycle; enables stay 0 while rst low.
- mispredict_ex=1 together with ld_use=1 → if_id_flush=id_ex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- halt_ex_dm=1 → halted=1 from the next cycle; later mispredict/dm inputs have no effect; async rst pulse returns to RUN with counters 0.
